cga_text_serializer: RTL and testbench

- Downstream of the mc6845 CRTC in the CGA sim.
- Consumes MA/RA/DISP_EN/CURSOR/HSYNC/VSYNC once per character slot and fetches the char/attr word from VRAM, then the glyph row from font ROM.
- Shifts 8 dots out at dot clock as RGBI, with syncs re-aligned to pixel timing.
- Text modes only; graphics modes are out of scope.

---
 rtl/cga_text_serializer_pkg.sv | 30 +++
 rtl/cga_attr_decode.sv | 35 +++
 rtl/cga_text_serializer.sv | 170 +++++++++++++++++
 tb/tb_cga_text_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_text_serializer_pkg.sv
// Shared definitions for the CGA text serializer and its colour decoder:
// attribute field positions, RGBI width, fetch pipeline offsets and the
// default blink bit.
package cga_text_serializer_pkg;

  localparam int unsigned RgbiW = 4;

  // Attribute byte layout: {blink/bg-intensity, bg[2:0], fg[3:0]}
  localparam int unsigned AttrFgLsb    = 0;
  localparam int unsigned AttrFgMsb    = 3;
  localparam int unsigned AttrBgLsb    = 4;
  localparam int unsigned AttrBgMsb    = 6;
  localparam int unsigned AttrBlinkBit = 7;

  // Fetch pipeline: cycles after the CCLK_EN edge at which the VRAM word and
  // the font row are valid on the memory outputs.
  localparam int unsigned StVramData = 2;
  localparam int unsigned StFontData = 4;

  localparam int unsigned DefaultBlinkBit = 4;

  // CRTC control bits carried alongside each character slot
  typedef struct packed {
    logic de;
    logic cursor;
    logic hsync;
    logic vsync;
  } crtc_ctrl_t;

endpackage

// File: rtl/cga_attr_decode.sv
// Per-dot colour selection for an attribute-based display: border while
// blanked, otherwise foreground/background from the attribute byte with
// blink and cursor applied. Purely combinational.
module cga_attr_decode
  import cga_text_serializer_pkg::*;
(
  input  logic [7:0]       attr_i,
  input  logic             blink_mode_i,
  input  logic             blink_phase_i,
  input  logic             cursor_i,
  input  logic             dot_i,
  input  logic             de_i,
  input  logic [RgbiW-1:0] border_i,
  output logic [RgbiW-1:0] rgbi_o
);

  logic [RgbiW-1:0] fg;
  logic [RgbiW-1:0] bg;
  logic             lit;

  // Pick fg/bg; blink-off hides the glyph, cursor overrides everything
  always_comb begin
    fg  = attr_i[AttrFgMsb:AttrFgLsb];
    bg  = {(blink_mode_i ? 1'b0 : attr_i[AttrBlinkBit]), attr_i[AttrBgMsb:AttrBgLsb]};
    lit = dot_i;
    if (blink_mode_i && attr_i[AttrBlinkBit] && !blink_phase_i) begin
      lit = 1'b0;
    end
    if (cursor_i) begin
      lit = 1'b1;
    end
    rgbi_o = de_i ? (lit ? fg : bg) : border_i;
  end

endmodule

// File: rtl/cga_text_serializer.sv
// CGA text-mode serializer: captures CRTC outputs once per character slot,
// fetches the char/attr word and glyph row, and shifts RGBI dots out one
// slot later with syncs aligned to the shifter load.
// Optional build macro: CGA_SER_SNOW_EN adds CPU_HIT/CPU_DATA, which replace
// the VRAM word during the data-latch cycle to model 80-column snow.
module cga_text_serializer
  import cga_text_serializer_pkg::*;
#(
  parameter int unsigned FONT_ROWS = 8,
  parameter int unsigned BLINK_BIT = DefaultBlinkBit
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CCLK_EN,
  input  logic [13:0]      MA,
  input  logic [4:0]       RA,
  input  logic             DISP_EN,
  input  logic             CURSOR,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic             BLINK_MODE,
  input  logic [RgbiW-1:0] BORDER,
  output logic [12:0]      VRAM_WADDR,
  input  logic [15:0]      VRAM_RDATA,
  output logic [10:0]      FONT_ADDR,
  input  logic [7:0]       FONT_DATA,
`ifdef CGA_SER_SNOW_EN
  input  logic             CPU_HIT,
  input  logic [7:0]       CPU_DATA,
`endif
  output logic [RgbiW-1:0] RGBI,
  output logic             HSYNC_O,
  output logic             VSYNC_O,
  output logic             DE_O
);

  localparam int unsigned RowBits  = $clog2(FONT_ROWS);
  localparam int unsigned FetchLen = StFontData;

  crtc_ctrl_t           ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
  logic [RowBits-1:0]   ra1_q, ra1_d;
  logic [12:0]          waddr_q, waddr_d;
  logic [FetchLen-1:0]  fetch_q, fetch_d;
  logic [7:0]           attr1_q, attr1_d, attr2_q, attr2_d;
  logic [10:0]          font_addr_q, font_addr_d;
  logic [7:0]           glyph_q, glyph_d, shift_q, shift_d;
  logic [5:0]           blink_cnt_q, blink_cnt_d;
  logic                 phase2_q, phase2_d;
  logic                 primed_q, primed_d, live_q, live_d;
  logic [15:0]          vram_word;
  logic [RgbiW-1:0]     dot_rgbi;

  // MA13 and the upper row bits are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MA[13], RA[4:RowBits]};

  // Word seen by the data-latch stage (CPU bus contention overrides VRAM)
  always_comb begin
`ifdef CGA_SER_SNOW_EN
    vram_word = CPU_HIT ? {CPU_DATA, CPU_DATA} : VRAM_RDATA;
`else
    vram_word = VRAM_RDATA;
`endif
  end

  // Stage-1 capture and the VRAM/font fetch sequence
  always_comb begin
    ctrl1_d     = ctrl1_q;
    ra1_d       = ra1_q;
    waddr_d     = waddr_q;
    fetch_d     = {fetch_q[FetchLen-2:0], CCLK_EN};
    attr1_d     = attr1_q;
    font_addr_d = font_addr_q;
    glyph_d     = glyph_q;
    blink_cnt_d = blink_cnt_q;
    if (CCLK_EN) begin
      ctrl1_d = '{de: DISP_EN, cursor: CURSOR, hsync: HSYNC, vsync: VSYNC};
      ra1_d   = RA[RowBits-1:0];
      waddr_d = MA[12:0];
      if (VSYNC && !ctrl1_q.vsync) begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
    if (fetch_q[StVramData-1]) begin
      attr1_d     = vram_word[15:8];
      font_addr_d = {vram_word[7:0], ra1_q};
    end
    if (fetch_q[StFontData-1]) begin
      glyph_d = FONT_DATA;
    end
  end

  // Stage-2 load at each slot boundary (skipped for the first slot after
  // reset, which has no fetched data yet); shifter drains zeros otherwise
  always_comb begin
    primed_d = primed_q;
    live_d   = live_q;
    ctrl2_d  = ctrl2_q;
    attr2_d  = attr2_q;
    phase2_d = phase2_q;
    shift_d  = {shift_q[6:0], 1'b0};
    if (CCLK_EN) begin
      primed_d = 1'b1;
      if (primed_q) begin
        live_d   = 1'b1;
        ctrl2_d  = ctrl1_q;
        attr2_d  = attr1_q;
        phase2_d = blink_cnt_q[BLINK_BIT];
        shift_d  = glyph_q;
      end
    end
  end

  // All state, asynchronously cleared
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl1_q     <= '0;
      ra1_q       <= '0;
      waddr_q     <= '0;
      fetch_q     <= '0;
      attr1_q     <= '0;
      font_addr_q <= '0;
      glyph_q     <= '0;
      blink_cnt_q <= '0;
      primed_q    <= 1'b0;
      live_q      <= 1'b0;
      ctrl2_q     <= '0;
      attr2_q     <= '0;
      phase2_q    <= 1'b0;
      shift_q     <= '0;
    end else begin
      ctrl1_q     <= ctrl1_d;
      ra1_q       <= ra1_d;
      waddr_q     <= waddr_d;
      fetch_q     <= fetch_d;
      attr1_q     <= attr1_d;
      font_addr_q <= font_addr_d;
      glyph_q     <= glyph_d;
      blink_cnt_q <= blink_cnt_d;
      primed_q    <= primed_d;
      live_q      <= live_d;
      ctrl2_q     <= ctrl2_d;
      attr2_q     <= attr2_d;
      phase2_q    <= phase2_d;
      shift_q     <= shift_d;
    end
  end

  cga_attr_decode u_attr_decode (
    .attr_i       (attr2_q),
    .blink_mode_i (BLINK_MODE),
    .blink_phase_i(phase2_q),
    .cursor_i     (ctrl2_q.cursor),
    .dot_i        (shift_q[7]),
    .de_i         (ctrl2_q.de),
    .border_i     (BORDER),
    .rgbi_o       (dot_rgbi)
  );

  // RGBI stays dark until the first real slot so reset reads as all-zero
  always_comb begin
    RGBI       = live_q ? dot_rgbi : '0;
    HSYNC_O    = ctrl2_q.hsync;
    VSYNC_O    = ctrl2_q.vsync;
    DE_O       = ctrl2_q.de;
    VRAM_WADDR = waddr_q;
    FONT_ADDR  = font_addr_q;
  end

endmodule

// File: tb/tb_cga_text_serializer.sv
// Bench for cga_text_serializer: sync VRAM/font models, one slot descriptor
// queued per CCLK_EN and checked dot by dot during the following slot.
module tb_cga_text_serializer;

  localparam int BlinkBit = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CCLK_EN = 1'b0;
  logic [13:0] MA = '0;
  logic [4:0]  RA = '0;
  logic        DISP_EN = 1'b0, CURSOR = 1'b0, HSYNC = 1'b0, VSYNC = 1'b0;
  logic        BLINK_MODE = 1'b0;
  logic [3:0]  BORDER = 4'h9;
  logic [12:0] VRAM_WADDR;
  logic [15:0] VRAM_RDATA = '0;
  logic [10:0] FONT_ADDR;
  logic [7:0]  FONT_DATA = '0;
  logic [3:0]  RGBI;
  logic        HSYNC_O, VSYNC_O, DE_O;
`ifdef CGA_SER_SNOW_EN
  logic        CPU_HIT = 1'b0;
  logic [7:0]  CPU_DATA = 8'h7F;
`endif

  cga_text_serializer #(
    .FONT_ROWS(8),
    .BLINK_BIT(BlinkBit)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .CCLK_EN   (CCLK_EN),
    .MA        (MA),
    .RA        (RA),
    .DISP_EN   (DISP_EN),
    .CURSOR    (CURSOR),
    .HSYNC     (HSYNC),
    .VSYNC     (VSYNC),
    .BLINK_MODE(BLINK_MODE),
    .BORDER    (BORDER),
    .VRAM_WADDR(VRAM_WADDR),
    .VRAM_RDATA(VRAM_RDATA),
    .FONT_ADDR (FONT_ADDR),
    .FONT_DATA (FONT_DATA),
`ifdef CGA_SER_SNOW_EN
    .CPU_HIT   (CPU_HIT),
    .CPU_DATA  (CPU_DATA),
`endif
    .RGBI      (RGBI),
    .HSYNC_O   (HSYNC_O),
    .VSYNC_O   (VSYNC_O),
    .DE_O      (DE_O)
  );

  always #5 CLK = ~CLK;

  // Synchronous memories, one cycle of read latency
  logic [15:0] vram [0:8191];
  logic [7:0]  font [0:2047];
  always @(posedge CLK) begin
    VRAM_RDATA <= vram[VRAM_WADDR];
    FONT_DATA  <= font[FONT_ADDR];
  end

  // Slot strobes closer than 5 cycles overlap the fetch in flight
  int cclk_gap = 100;
  always @(posedge CLK) begin
    if (CCLK_EN) begin
      assert (cclk_gap >= 5) else $error("CCLK_EN spacing %0d below 5", cclk_gap);
      cclk_gap <= 1;
    end else if (cclk_gap < 100) begin
      cclk_gap <= cclk_gap + 1;
    end
  end

  typedef struct {
    logic [7:0] glyph;
    logic [7:0] attr;
    logic       de, cursor, hs, vs, phase;
  } desc_t;

  desc_t      sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         m_slots = 0;
  logic [5:0] m_cnt = '0;
  logic       m_prev_vs = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {RGBI, HSYNC_O, VSYNC_O, DE_O} for dot i of a displayed slot
  function automatic logic [6:0] exp_out(input desc_t d, input int i);
    logic       lit;
    logic [3:0] fg, bg, c;
    fg  = d.attr[3:0];
    bg  = BLINK_MODE ? {1'b0, d.attr[6:4]} : d.attr[7:4];
    lit = (i < 8) ? d.glyph[7-i] : 1'b0;
    if (BLINK_MODE && d.attr[7] && !d.phase) lit = 1'b0;
    if (d.cursor) lit = 1'b1;
    c = d.de ? (lit ? fg : bg) : BORDER;
    return {c, d.hs, d.vs, d.de};
  endfunction

  // Drive one character slot; rst_at >= 0 pulls reset mid-slot at that dot
  task automatic run_slot(input logic [13:0] ma, input logic [4:0] ra, input logic de,
                          input logic cur, input logic hs, input logic vs, input int period,
                          input logic snow, input int rst_at);
    desc_t       d, shown;
    logic        have;
    logic [15:0] w;
    logic [7:0]  ch, at;
    logic [6:0]  e;
    w  = vram[ma[12:0]];
    ch = w[7:0];
    at = w[15:8];
    if (snow) begin
      ch = 8'h7F;
      at = 8'h7F;
    end
    if (vs && !m_prev_vs) m_cnt = m_cnt + 6'd1;
    m_prev_vs = vs;
    d.glyph  = font[{ch, ra[2:0]}];
    d.attr   = at;
    d.de     = de;
    d.cursor = cur;
    d.hs     = hs;
    d.vs     = vs;
    d.phase  = m_cnt[BlinkBit];
    have     = 1'b0;
    shown    = d;
    if (m_slots > 0) begin
      if (sb.size() > 0) begin
        shown = sb.pop_front();
        have  = 1'b1;
      end else begin
        check_eq("scoreboard_empty", 32'd0, 32'd1);
      end
    end
    sb.push_back(d);
    m_slots++;
    MA = ma; RA = ra; DISP_EN = de; CURSOR = cur; HSYNC = hs; VSYNC = vs;
    CCLK_EN = 1'b1;
    for (int i = 0; i < period; i++) begin
      @(posedge CLK);
      #1;
      CCLK_EN = 1'b0;
`ifdef CGA_SER_SNOW_EN
      CPU_HIT = (i == 1) && snow;
`endif
      if (i == 0) check_eq("vram_waddr", {19'd0, VRAM_WADDR}, {19'd0, ma[12:0]});
      if (i == 2) check_eq("font_addr", {21'd0, FONT_ADDR}, {21'd0, ch, ra[2:0]});
      e = have ? exp_out(shown, i) : 7'd0;
      check_eq($sformatf("slot%0d_dot%0d", m_slots, i),
               {25'd0, RGBI, HSYNC_O, VSYNC_O, DE_O}, {25'd0, e});
      if (i == rst_at) begin
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {1'b0, RGBI, HSYNC_O, VSYNC_O, DE_O, VRAM_WADDR, FONT_ADDR}, 32'd0);
        sb.delete();
        m_slots   = 0;
        m_cnt     = '0;
        m_prev_vs = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) vram[a] = '0;
    for (int a = 0; a < 2048; a++) font[a] = '0;
    vram[5]  = 16'h1E41;
    font[{8'h41, 3'd2}] = 8'hC3;
    vram[6]  = 16'h8F02;
    font[{8'h02, 3'd1}] = 8'hFF;
    vram[7]  = 16'h8F03;
    vram[8]  = 16'h9E04;
    vram[9]  = 16'h1E04;
    font[{8'h7F, 3'd2}] = 8'hAA;

    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_outputs",
             {1'b0, RGBI, HSYNC_O, VSYNC_O, DE_O, VRAM_WADDR, FONT_ADDR}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Basic glyph, MA13 wrap with border, then show the border slot
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);
    run_slot(14'h2005, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);

    // Blink: 32 VSYNC rises walk the phase 0 -> 1 -> 0
    BLINK_MODE = 1'b1;
    for (int j = 0; j < 64; j++) begin
      run_slot(14'h0006, 5'd1, 1'b1, 1'b0, 1'b0, (j % 2) == 0, 5, 1'b0, -1);
    end
    BLINK_MODE = 1'b0;
    run_slot(14'h0007, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 1'b0, -1);
    run_slot(14'h0007, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 1'b0, -1);

    // Cursor during blink-off phase, then without cursor
    BLINK_MODE = 1'b1;
    run_slot(14'h0008, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8, 1'b0, -1);
    run_slot(14'h0009, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8, 1'b0, -1);
    run_slot(14'h0008, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);
    run_slot(14'h0008, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);

    // HSYNC slots 3..5 with 10-dot slots
    BLINK_MODE = 1'b0;
    for (int j = 0; j < 8; j++) begin
      run_slot(14'h0005, 5'd2, 1'b1, 1'b0, (j >= 3) && (j <= 5), 1'b0, 10, 1'b0, -1);
    end

    // Reset asserted mid-slot while syncs and DE are high
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b0, -1);
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, 3);
    #3;
    RESET_N = 1'b1;
    repeat (6) @(posedge CLK);
    #1;

`ifdef CGA_SER_SNOW_EN
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1, -1);
`else
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);
`endif
    run_slot(14'h0005, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);
    run_slot(14'h0006, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
